// File: rtl/peecc_check_pipeline_pkg.sv
// Shared widths and helpers for the PEECC self-check pipeline.
package peecc_pkg;

  localparam int PEECC_DATA_W = 32'sd18;
  localparam int PEECC_DEPTH  = 32'sd11;
  localparam int PEECC_CNT_W  = 32'sd16;

  // Ceiling log2, used for FIFO pointer widths.
  function automatic int clog2(input int value);
    int r;
    r = 32'sd0;
    while ((32'sd1 << r) < value) begin
      r = r + 32'sd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/peecc_check_pipeline_if.sv
// Data/decoder handshake and status bundle for peecc_check_pipeline.
interface peecc_check_pipeline_if
  import peecc_pkg::*;
#(
  parameter int DATA_W = PEECC_DATA_W,
  parameter int DEPTH  = PEECC_DEPTH,
  parameter int CNT_W  = PEECC_CNT_W
);

  logic                    ValidIn;
  logic [DATA_W-1:0]       DataIn;
  logic                    DecValid;
  logic [DATA_W-1:0]       DecData;
  logic [DEPTH*DATA_W-1:0] registers;
  logic                    IsEqual;
  logic                    CmpValid;
  logic [CNT_W-1:0]        WordCnt;
  logic [CNT_W-1:0]        ErrCnt;
  logic                    Overflow;
  logic                    Underflow;

  modport master (
    output ValidIn, DataIn, DecValid, DecData,
    input  registers, IsEqual, CmpValid, WordCnt, ErrCnt, Overflow, Underflow
  );

  modport slave (
    input  ValidIn, DataIn, DecValid, DecData,
    output registers, IsEqual, CmpValid, WordCnt, ErrCnt, Overflow, Underflow
  );

endinterface

// File: rtl/peecc_check_pipeline_ref_fifo.sv
// Synchronous alignment FIFO; push into a full FIFO only succeeds alongside a pop.
module peecc_ref_fifo
  import peecc_pkg::*;
#(
  parameter int DATA_W     = PEECC_DATA_W,
  parameter int FIFO_DEPTH = 32'sd8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W:0]    count_r;
  logic              do_push_s;
  logic              do_pop_s;

  assign full      = (count_r == (PTR_W+1)'(FIFO_DEPTH));
  assign empty     = (count_r == {(PTR_W+1){1'b0}});
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);
  assign dout      = mem_r[rd_ptr_r];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge CLK) begin
    if (do_push_s && !RST) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers wrap naturally; occupancy count decides full/empty.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (PTR_W+1)'(1'b1);
        2'b01:   count_r <= count_r - (PTR_W+1)'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/peecc_check_pipeline.sv
// Self-check stage beside the PEECC encoder/decoder: history bank, aligned compare, counters.
// Optional build macro PEECC_STICKY_ERR_EN latches IsEqual low after the first mismatch.
module peecc_check_pipeline
  import peecc_pkg::*;
#(
  parameter int DATA_W     = PEECC_DATA_W,
  parameter int DEPTH      = PEECC_DEPTH,
  parameter int FIFO_DEPTH = 32'sd8,
  parameter int CNT_W      = PEECC_CNT_W
) (
  input logic                   CLK,
  input logic                   RST,
  peecc_check_pipeline_if.slave bus
);

  logic [DEPTH*DATA_W-1:0] bank_r;
  logic                    is_equal_r;
  logic                    cmp_valid_r;
  logic                    overflow_r;
  logic                    underflow_r;
  logic [CNT_W-1:0]        word_cnt_r;
  logic [CNT_W-1:0]        err_cnt_r;

  logic                    fifo_full_s;
  logic                    fifo_empty_s;
  logic [DATA_W-1:0]       head_s;
  logic                    pop_ok_s;
  logic                    match_s;
  logic                    eq_next_s;
  logic                    drop_s;
  logic                    underrun_s;

  assign pop_ok_s   = bus.DecValid && !fifo_empty_s;
  assign match_s    = (bus.DecData == head_s);
  assign drop_s     = bus.ValidIn && fifo_full_s && !pop_ok_s;
  assign underrun_s = bus.DecValid && fifo_empty_s;

`ifdef PEECC_STICKY_ERR_EN
  logic seen_err_r;

  assign eq_next_s = match_s && !seen_err_r;

  // Remembers that any compare has failed since reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      seen_err_r <= 1'b0;
    end else if (pop_ok_s && !match_s) begin
      seen_err_r <= 1'b1;
    end
  end
`else
  assign eq_next_s = match_s;
`endif

  peecc_ref_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_ref_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (bus.ValidIn),
    .pop   (bus.DecValid),
    .din   (bus.DataIn),
    .dout  (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // History bank: newest word in the low slot, oldest falls off the top.
  always_ff @(posedge CLK) begin
    if (RST) begin
      bank_r <= {(DEPTH*DATA_W){1'b0}};
    end else if (bus.ValidIn) begin
      bank_r <= {bank_r[(DEPTH-1)*DATA_W-1:0], bus.DataIn};
    end
  end

  // Registered compare result, saturating counters and sticky FIFO status.
  always_ff @(posedge CLK) begin
    if (RST) begin
      is_equal_r  <= 1'b0;
      cmp_valid_r <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
      word_cnt_r  <= {CNT_W{1'b0}};
      err_cnt_r   <= {CNT_W{1'b0}};
    end else begin
      cmp_valid_r <= pop_ok_s;
      if (pop_ok_s) begin
        is_equal_r <= eq_next_s;
        if (word_cnt_r != {CNT_W{1'b1}}) begin
          word_cnt_r <= word_cnt_r + CNT_W'(1'b1);
        end
        if (!match_s && (err_cnt_r != {CNT_W{1'b1}})) begin
          err_cnt_r <= err_cnt_r + CNT_W'(1'b1);
        end
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
      if (underrun_s) begin
        underflow_r <= 1'b1;
      end
    end
  end

  assign bus.registers = bank_r;
  assign bus.IsEqual   = is_equal_r;
  assign bus.CmpValid  = cmp_valid_r;
  assign bus.WordCnt   = word_cnt_r;
  assign bus.ErrCnt    = err_cnt_r;
  assign bus.Overflow  = overflow_r;
  assign bus.Underflow = underflow_r;

endmodule

// File: tb/tb_peecc_check_pipeline.sv
// Self-checking bench: two DUTs (CNT_W=16 and CNT_W=3) share stimulus and a queue-based model.
module tb_peecc_check_pipeline;

  localparam int DATA_W = 18;
  localparam int DEPTH  = 11;
  localparam int FDEPTH = 8;
  localparam int BW     = DEPTH * DATA_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              valid = 1'b0;
  logic [DATA_W-1:0] din = '0;
  logic              decv = 1'b0;
  logic [DATA_W-1:0] decd = '0;

  int total = 0;
  int bad   = 0;

  peecc_check_pipeline_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(16)) bus_a ();
  peecc_check_pipeline_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(3))  bus_b ();

  assign bus_a.ValidIn  = valid;
  assign bus_a.DataIn   = din;
  assign bus_a.DecValid = decv;
  assign bus_a.DecData  = decd;
  assign bus_b.ValidIn  = valid;
  assign bus_b.DataIn   = din;
  assign bus_b.DecValid = decv;
  assign bus_b.DecData  = decd;

  peecc_check_pipeline #(.DATA_W(DATA_W), .DEPTH(DEPTH), .FIFO_DEPTH(FDEPTH), .CNT_W(16)) dut_a (
    .CLK (clk), .RST (rst), .bus (bus_a.slave));
  peecc_check_pipeline #(.DATA_W(DATA_W), .DEPTH(DEPTH), .FIFO_DEPTH(FDEPTH), .CNT_W(3)) dut_b (
    .CLK (clk), .RST (rst), .bus (bus_b.slave));

  always #5 clk = ~clk;

  // Reference model state
  logic [DATA_W-1:0] m_bank[$];
  logic [DATA_W-1:0] m_fifo[$];
  int m_words, m_errs;
  bit m_cmp_valid, m_is_equal, m_ovf, m_unf, m_seen_err;

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int lim;
    lim = (1 << w) - 1;
    return (v > lim) ? lim : v;
  endfunction

  function automatic logic [BW-1:0] exp_bank();
    logic [BW-1:0] r;
    r = '0;
    for (int i = 0; i < DEPTH; i++) r[i*DATA_W +: DATA_W] = m_bank[i];
    return r;
  endfunction

  task automatic model_update();
    int sz;
    bit pop, push, eq;
    logic [DATA_W-1:0] head;
    if (rst) begin
      m_bank = {};
      for (int i = 0; i < DEPTH; i++) m_bank.push_back('0);
      m_fifo = {};
      m_words = 0; m_errs = 0;
      m_cmp_valid = 0; m_is_equal = 0; m_ovf = 0; m_unf = 0; m_seen_err = 0;
    end else begin
      sz   = m_fifo.size();
      pop  = decv && (sz > 0);
      push = valid && ((sz < FDEPTH) || pop);
      m_cmp_valid = pop;
      if (pop) begin
        head = m_fifo.pop_front();
        eq = (head == decd);
        m_words++;
        if (!eq) m_errs++;
`ifdef PEECC_STICKY_ERR_EN
        if (!eq) m_seen_err = 1;
        m_is_equal = eq && !m_seen_err;
`else
        m_is_equal = eq;
`endif
      end
      if (decv && sz == 0) m_unf = 1;
      if (valid && !push) m_ovf = 1;
      if (push) m_fifo.push_back(din);
      if (valid) begin
        m_bank.push_front(din);
        void'(m_bank.pop_back());
      end
    end
  endtask

  task automatic check_all();
    chk("registers",   bus_a.registers, exp_bank());
    chk("IsEqual",     BW'(bus_a.IsEqual),   BW'(m_is_equal));
    chk("CmpValid",    BW'(bus_a.CmpValid),  BW'(m_cmp_valid));
    chk("Overflow",    BW'(bus_a.Overflow),  BW'(m_ovf));
    chk("Underflow",   BW'(bus_a.Underflow), BW'(m_unf));
    chk("WordCnt",     BW'(bus_a.WordCnt),   BW'(sat(m_words, 16)));
    chk("ErrCnt",      BW'(bus_a.ErrCnt),    BW'(sat(m_errs, 16)));
    chk("b_registers", bus_b.registers, exp_bank());
    chk("b_IsEqual",   BW'(bus_b.IsEqual),   BW'(m_is_equal));
    chk("b_CmpValid",  BW'(bus_b.CmpValid),  BW'(m_cmp_valid));
    chk("b_Overflow",  BW'(bus_b.Overflow),  BW'(m_ovf));
    chk("b_Underflow", BW'(bus_b.Underflow), BW'(m_unf));
    chk("b_WordCnt",   BW'(bus_b.WordCnt),   BW'(sat(m_words, 3)));
    chk("b_ErrCnt",    BW'(bus_b.ErrCnt),    BW'(sat(m_errs, 3)));
  endtask

  task automatic step(input logic v, input logic [DATA_W-1:0] d,
                      input logic dv, input logic [DATA_W-1:0] dd);
    valid = v; din = d; decv = dv; decd = dd;
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, '0, 1'b0, '0);
    rst = 1'b0;
  endtask

  logic [DATA_W-1:0] w [10];

  initial begin
    // Reset state
    do_reset();
    chk("reset_regs", bus_a.registers, '0);
    chk("reset_wcnt", BW'(bus_a.WordCnt), '0);

    // Bank fill with 1..12
    for (int i = 1; i <= 12; i++) step(1'b1, DATA_W'(i), 1'b0, '0);
    chk("slot0", BW'(bus_a.registers[DATA_W-1:0]), BW'(12));
    chk("slot10", BW'(bus_a.registers[10*DATA_W +: DATA_W]), BW'(2));

    // Three matching compares after a delay
    do_reset();
    for (int i = 0; i < 3; i++) begin
      w[i] = DATA_W'($urandom);
      step(1'b1, w[i], 1'b0, '0);
    end
    step(1'b0, '0, 1'b0, '0);
    step(1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, w[i]);
    chk("t2_wcnt", BW'(bus_a.WordCnt), BW'(3));
    chk("t2_ecnt", BW'(bus_a.ErrCnt), BW'(0));
    chk("t2_eq", BW'(bus_a.IsEqual), BW'(1));

    // Second decoded word corrupted in bit 0
    do_reset();
    for (int i = 0; i < 3; i++) begin
      w[i] = DATA_W'($urandom);
      step(1'b1, w[i], 1'b0, '0);
    end
    step(1'b0, '0, 1'b1, w[0]);
    step(1'b0, '0, 1'b1, w[1] ^ DATA_W'(1));
    chk("t3_eq2", BW'(bus_a.IsEqual), BW'(0));
    step(1'b0, '0, 1'b1, w[2]);
    chk("t3_ecnt", BW'(bus_a.ErrCnt), BW'(1));
`ifdef PEECC_STICKY_ERR_EN
    chk("t3_eq3", BW'(bus_a.IsEqual), BW'(0));
`else
    chk("t3_eq3", BW'(bus_a.IsEqual), BW'(1));
`endif

    // Overflow on the 9th push, then 8 in-order pops
    do_reset();
    for (int i = 0; i < 9; i++) begin
      w[i] = DATA_W'($urandom);
      step(1'b1, w[i], 1'b0, '0);
    end
    chk("t4_ovf", BW'(bus_a.Overflow), BW'(1));
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, w[i]);
    chk("t4_wcnt", BW'(bus_a.WordCnt), BW'(8));
    chk("t4_ecnt", BW'(bus_a.ErrCnt), BW'(0));

    // Underflow on empty FIFO
    step(1'b0, '0, 1'b1, DATA_W'($urandom));
    chk("t5_unf", BW'(bus_a.Underflow), BW'(1));
    chk("t5_cmpv", BW'(bus_a.CmpValid), BW'(0));
    chk("t5_wcnt", BW'(bus_a.WordCnt), BW'(8));

    // Full FIFO with simultaneous push+pop
    do_reset();
    for (int i = 0; i < 8; i++) begin
      w[i] = DATA_W'($urandom);
      step(1'b1, w[i], 1'b0, '0);
    end
    w[8] = DATA_W'($urandom);
    step(1'b1, w[8], 1'b1, w[0]);
    chk("t5_ovf", BW'(bus_a.Overflow), BW'(0));
    for (int i = 1; i <= 8; i++) step(1'b0, '0, 1'b1, w[i]);
    chk("t5_drain", BW'(bus_a.WordCnt), BW'(9));
    chk("t5_unf0", BW'(bus_a.Underflow), BW'(0));

    // Reset mid-stream with 4 words queued, inputs active in reset cycle
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, DATA_W'($urandom), 1'b0, '0);
    rst = 1'b1;
    step(1'b1, DATA_W'($urandom), 1'b1, DATA_W'($urandom));
    rst = 1'b0;
    chk("t6_regs", bus_a.registers, '0);
    chk("t6_wcnt", BW'(bus_a.WordCnt), '0);
    chk("t6_cmpv", BW'(bus_a.CmpValid), '0);

    // Nine mismatching compares: 3-bit counters saturate at 7
    for (int i = 0; i < 9; i++) begin
      w[0] = DATA_W'($urandom);
      step(1'b1, w[0], 1'b0, '0);
      step(1'b0, '0, 1'b1, w[0] ^ DATA_W'(1));
    end
    chk("t6_b_wcnt", BW'(bus_b.WordCnt), BW'(7));
    chk("t6_b_ecnt", BW'(bus_b.ErrCnt), BW'(7));
    chk("t6_a_wcnt", BW'(bus_a.WordCnt), BW'(9));

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [DATA_W-1:0] dd;
      if (m_fifo.size() > 0 && $urandom_range(0, 3) != 0) dd = m_fifo[0];
      else dd = DATA_W'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        step($urandom_range(0, 1) == 1, DATA_W'($urandom), $urandom_range(0, 1) == 1, dd);
        rst = 1'b0;
      end else begin
        step($urandom_range(0, 2) != 0, DATA_W'($urandom), $urandom_range(0, 2) != 0, dd);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
